mtime_accessor: RTL and testbench

MTIME_ACCESSOR -- requirements
Module: mtime_accessor

---
 rtl/mtime_accessor.sv | 140 ++++++++++++++
 tb/tb_mtime_accessor.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtime_accessor.sv
// Tear-free 64-bit access to a memory-mapped RISC-V timer over an XLEN-wide bus.
// Reads use hi/lo/hi with bounded retry; mtimecmp writes park the low half at all-ones first.
module mtime_accessor #(
    parameter int              XLEN              = 32,
    parameter logic [XLEN-1:0] MTIME_ADDR_LOW    = XLEN'(32'h0200_BFF8),
    parameter logic [XLEN-1:0] MTIME_ADDR_HIGH   = XLEN'(32'h0200_BFFC),
    parameter logic [XLEN-1:0] MTIMECMP_ADDR_LOW = XLEN'(32'h0200_4000),
    parameter logic [XLEN-1:0] MTIMECMP_ADDR_HIGH = XLEN'(32'h0200_4004)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [63:0]     req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mtime_addr_o,
    output logic            mtime_write_valid_o,
    output logic [XLEN-1:0] mtime_wdata_o,
    input  logic [XLEN-1:0] mtime_rdata_i
);

    typedef enum logic [2:0] {
        IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO_MAX, WR_HI, WR_LO, RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        op_q;
    logic [63:0] wdata_q;
    logic [31:0] hi1;
    logic [31:0] lo;
    logic [1:0]  retry;
    logic [31:0] rd_word;
    logic        hi_match;

    assign rd_word  = mtime_rdata_i[31:0];
    assign hi_match = (rd_word == hi1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (req_valid) state_nxt = req_op ? WR_LO_MAX : RD_HI1;
            RD_HI1:    state_nxt = RD_LO;
            RD_LO:     state_nxt = RD_HI2;
            RD_HI2:    state_nxt = (hi_match || retry == 2'd3) ? RESP : RD_LO;
            WR_LO_MAX: state_nxt = WR_HI;
            WR_HI:     state_nxt = WR_LO;
            WR_LO:     state_nxt = RESP;
            RESP:      if (resp_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bus signals are pure functions of the state so every bus phase lasts one cycle.
    always_comb begin
        req_ready           = 1'b0;
        resp_valid          = 1'b0;
        mtime_addr_o        = '0;
        mtime_write_valid_o = 1'b0;
        mtime_wdata_o       = '0;
        case (state)
            IDLE:   req_ready = 1'b1;
            RD_HI1: mtime_addr_o = MTIME_ADDR_HIGH;
            RD_LO:  mtime_addr_o = MTIME_ADDR_LOW;
            RD_HI2: mtime_addr_o = MTIME_ADDR_HIGH;
            WR_LO_MAX: begin
                mtime_addr_o        = MTIMECMP_ADDR_LOW;
                mtime_write_valid_o = op_q;
                mtime_wdata_o       = op_q ? '1 : '0;
            end
            WR_HI: begin
                mtime_addr_o        = MTIMECMP_ADDR_HIGH;
                mtime_write_valid_o = op_q;
                mtime_wdata_o       = op_q ? XLEN'(wdata_q[63:32]) : '0;
            end
            WR_LO: begin
                mtime_addr_o        = MTIMECMP_ADDR_LOW;
                mtime_write_valid_o = op_q;
                mtime_wdata_o       = op_q ? XLEN'(wdata_q[31:0]) : '0;
            end
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 1'b0;
            wdata_q    <= '0;
            hi1        <= '0;
            lo         <= '0;
            retry      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        wdata_q <= req_wdata;
                        retry   <= '0;
                    end
                end
                RD_HI1: hi1 <= rd_word;
                RD_LO:  lo  <= rd_word;
                RD_HI2: begin
                    // A changed high half means lo may have wrapped; resample lo against the new high.
                    if (hi_match) begin
                        resp_rdata <= {hi1, lo};
                        resp_err   <= 1'b0;
                    end else if (retry == 2'd3) begin
                        resp_rdata <= {rd_word, lo};
                        resp_err   <= 1'b1;
                    end else begin
                        hi1   <= rd_word;
                        retry <= retry + 2'd1;
                    end
                end
                WR_LO: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mtime_accessor.sv
// Bench for mtime_accessor: scripted timer bus model, bus-activity log and response scoreboard.
module tb_mtime_accessor;

    localparam int          XLEN  = 32;
    localparam logic [31:0] A_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_HI  = 32'h0200_BFFC;
    localparam logic [31:0] C_LO  = 32'h0200_4000;
    localparam logic [31:0] C_HI  = 32'h0200_4004;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_op = 1'b0;
    logic [63:0]     req_wdata = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [63:0]     resp_rdata;
    logic            resp_err;
    logic [XLEN-1:0] mtime_addr_o;
    logic            mtime_write_valid_o;
    logic [XLEN-1:0] mtime_wdata_o;
    logic [XLEN-1:0] mtime_rdata_i;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    bus_t        bus_q[$];
    exp_t        exp_q[$];
    logic [31:0] script[16];
    int          rd_count = 0;
    int          rd_base  = 0;
    int          idx;
    int          checks = 0;
    int          errors = 0;

    mtime_accessor #(
        .XLEN(XLEN), .MTIME_ADDR_LOW(A_LO), .MTIME_ADDR_HIGH(A_HI),
        .MTIMECMP_ADDR_LOW(C_LO), .MTIMECMP_ADDR_HIGH(C_HI)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mtime_addr_o(mtime_addr_o), .mtime_write_valid_o(mtime_write_valid_o),
        .mtime_wdata_o(mtime_wdata_o), .mtime_rdata_i(mtime_rdata_i)
    );

    always #5 clk = ~clk;

    // Timer model: each bus read returns the next scripted word.
    always_comb begin
        idx           = rd_count - rd_base;
        mtime_rdata_i = '0;
        if ((mtime_addr_o == A_LO || mtime_addr_o == A_HI) && idx >= 0 && idx < 16)
            mtime_rdata_i = script[idx];
    end

    always @(posedge clk) begin
        if (mtime_addr_o != '0) begin
            bus_q.push_back('{mtime_write_valid_o, mtime_addr_o, mtime_wdata_o});
            if (!mtime_write_valid_o) rd_count++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bus_t bus_at(input int i);
        if (i < bus_q.size()) return bus_q[i];
        return '0;
    endfunction

    task automatic start(input logic op, input logic [63:0] wd);
        @(negedge clk);
        req_op = op; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_op = 1'b0; req_wdata = '0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) lat = -1;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic set_script3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        for (int i = 0; i < 16; i++) script[i] = '0;
        script[0] = a; script[1] = b; script[2] = c;
        rd_base = rd_count;
    endtask

    task automatic test_reset();
        logic [131:0] obs;
        logic [131:0] exp_v;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {req_ready, resp_valid, resp_err, mtime_write_valid_o, resp_rdata, mtime_addr_o, mtime_wdata_o};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_during: got %h expected %h", obs, exp_v); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        obs = {req_ready, resp_valid, resp_err, mtime_write_valid_o, resp_rdata, mtime_addr_o, mtime_wdata_o};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_after: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_read_stable();
        int   lat, nb;
        exp_t e;
        logic [95:0] addrs;
        set_script3(32'h0000_0001, 32'h0000_1234, 32'h0000_0001);
        nb = bus_q.size();
        exp_q.push_back('{64'h0000_0001_0000_1234, 1'b0, 4});
        start(1'b0, '0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, e.lat); end
        checks++;
        if (resp_rdata !== e.rdata) begin errors++; $display("FAIL read_data: got %h expected %h", resp_rdata, e.rdata); end
        checks++;
        if (resp_err !== e.err) begin errors++; $display("FAIL read_err: got %b expected %b", resp_err, e.err); end
        checks++;
        if (bus_q.size() - nb !== 3) begin errors++; $display("FAIL read_bus_count: got %0d expected 3", bus_q.size() - nb); end
        addrs = {bus_at(nb).addr, bus_at(nb + 1).addr, bus_at(nb + 2).addr};
        checks++;
        if (addrs !== {A_HI, A_LO, A_HI} || bus_at(nb).we || bus_at(nb + 1).we || bus_at(nb + 2).we) begin
            errors++; $display("FAIL read_bus_addrs: got %h expected %h", addrs, {A_HI, A_LO, A_HI});
        end
        finish_resp();
    endtask

    task automatic test_read_retry();
        int   lat, nb;
        exp_t e;
        logic [159:0] addrs;
        set_script3(32'h0000_0005, 32'h0000_0000, 32'h0000_0006);
        script[3] = 32'h0000_0000; script[4] = 32'h0000_0006;
        nb = bus_q.size();
        exp_q.push_back('{64'h0000_0006_0000_0000, 1'b0, 6});
        start(1'b0, '0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL retry_latency: got %0d expected %0d", lat, e.lat); end
        checks++;
        if (resp_rdata !== e.rdata) begin errors++; $display("FAIL retry_data: got %h expected %h", resp_rdata, e.rdata); end
        checks++;
        if (resp_err !== e.err) begin errors++; $display("FAIL retry_err: got %b expected %b", resp_err, e.err); end
        addrs = {bus_at(nb).addr, bus_at(nb + 1).addr, bus_at(nb + 2).addr, bus_at(nb + 3).addr, bus_at(nb + 4).addr};
        checks++;
        if (bus_q.size() - nb !== 5 || addrs !== {A_HI, A_LO, A_HI, A_LO, A_HI}) begin
            errors++; $display("FAIL retry_bus: got %0d accesses %h expected 5 accesses %h", bus_q.size() - nb, addrs, {A_HI, A_LO, A_HI, A_LO, A_HI});
        end
        finish_resp();
    endtask

    task automatic test_write();
        int   lat, nb;
        exp_t e;
        bus_t b0, b1, b2;
        nb = bus_q.size();
        exp_q.push_back('{64'h0, 1'b0, 4});
        start(1'b1, 64'h0000_0002_8000_0000);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, e.lat); end
        checks++;
        if ({resp_rdata, resp_err} !== {e.rdata, e.err}) begin
            errors++; $display("FAIL write_resp: got %h/%b expected %h/%b", resp_rdata, resp_err, e.rdata, e.err);
        end
        checks++;
        if (bus_q.size() - nb !== 3) begin errors++; $display("FAIL write_strobe_count: got %0d expected 3", bus_q.size() - nb); end
        b0 = bus_at(nb); b1 = bus_at(nb + 1); b2 = bus_at(nb + 2);
        checks++;
        if ({b0, b1, b2} !== {{1'b1, C_LO, 32'hFFFF_FFFF}, {1'b1, C_HI, 32'h0000_0002}, {1'b1, C_LO, 32'h8000_0000}}) begin
            errors++; $display("FAIL write_sequence: got %h %h %h expected %h %h %h", b0, b1, b2,
                {1'b1, C_LO, 32'hFFFF_FFFF}, {1'b1, C_HI, 32'h0000_0002}, {1'b1, C_LO, 32'h8000_0000});
        end
        finish_resp();
    endtask

    task automatic test_read_error();
        int   lat, nb, bad;
        exp_t e;
        for (int i = 0; i < 16; i++) script[i] = '0;
        for (int i = 0; i < 9; i++) script[i] = (i % 2 == 0) ? 32'h100 + 32'(i / 2) : 32'hA + 32'(i / 2);
        rd_base = rd_count;
        nb = bus_q.size();
        exp_q.push_back('{64'h0000_0104_0000_000D, 1'b1, 10});
        start(1'b0, '0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL error_latency: got %0d expected %0d", lat, e.lat); end
        checks++;
        if (resp_rdata !== e.rdata) begin errors++; $display("FAIL error_data: got %h expected %h", resp_rdata, e.rdata); end
        checks++;
        if (resp_err !== e.err) begin errors++; $display("FAIL error_flag: got %b expected %b", resp_err, e.err); end
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (bus_at(nb + i).addr !== ((i % 2 == 0) ? A_HI : A_LO) || bus_at(nb + i).we) bad++;
        checks++;
        if (bus_q.size() - nb !== 9 || bad != 0) begin
            errors++; $display("FAIL error_bus: got %0d accesses %0d wrong expected 9 accesses 0 wrong", bus_q.size() - nb, bad);
        end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        exp_q.push_back('{64'h0, 1'b0, 4});
        exp_q.push_back('{64'hABCD_0000_0000_0042, 1'b0, 4});
        start(1'b1, 64'h1111_2222_3333_4444);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if ({lat, resp_rdata, resp_err} !== {e.lat, e.rdata, e.err}) begin
            errors++; $display("FAIL b2b_write: got %0d/%h/%b expected %0d/%h/%b", lat, resp_rdata, resp_err, e.lat, e.rdata, e.err);
        end
        finish_resp();
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL b2b_idle: got %b expected 10", {req_ready, resp_valid}); end
        set_script3(32'hABCD_0000, 32'h0000_0042, 32'hABCD_0000);
        start(1'b0, '0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if ({lat, resp_rdata, resp_err} !== {e.lat, e.rdata, e.err}) begin
            errors++; $display("FAIL b2b_read: got %0d/%h/%b expected %0d/%h/%b", lat, resp_rdata, resp_err, e.lat, e.rdata, e.err);
        end
        finish_resp();
    endtask

    task automatic test_hold();
        int   lat, nb;
        exp_t e;
        set_script3(32'h0000_0007, 32'h0000_0008, 32'h0000_0007);
        exp_q.push_back('{64'h0000_0007_0000_0008, 1'b0, 4});
        start(1'b0, '0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL hold_latency: got %0d expected %0d", lat, e.lat); end
        nb = bus_q.size();
        req_valid = 1'b1; req_op = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, req_ready, resp_rdata, resp_err} !== {1'b1, 1'b0, e.rdata, e.err}) begin
                errors++; $display("FAIL hold_cycle%0d: got %b/%b/%h/%b expected 1/0/%h/%b", i, resp_valid, req_ready, resp_rdata, resp_err, e.rdata, e.err);
            end
        end
        req_valid = 1'b0; req_op = 1'b0;
        checks++;
        if (bus_q.size() !== nb) begin errors++; $display("FAIL hold_no_strobes: got %0d accesses expected 0", bus_q.size() - nb); end
        finish_resp();
    endtask

    task automatic test_reset_mid_write();
        int           lat, nb;
        exp_t         e;
        logic [131:0] obs;
        logic [131:0] exp_v;
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0};
        nb = bus_q.size();
        start(1'b1, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        checks++;
        if ({mtime_addr_o, mtime_write_valid_o, mtime_wdata_o} !== {C_HI, 1'b1, 32'h1234_5678}) begin
            errors++; $display("FAIL midrst_in_wr_hi: got %h/%b/%h expected %h/1/12345678", mtime_addr_o, mtime_write_valid_o, mtime_wdata_o, C_HI);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        obs = {req_ready, resp_valid, resp_err, mtime_write_valid_o, resp_rdata, mtime_addr_o, mtime_wdata_o};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_outputs: got %h expected %h", obs, exp_v); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus_q.size() - nb !== 2) begin errors++; $display("FAIL midrst_strobes: got %0d expected 2", bus_q.size() - nb); end
        set_script3(32'h0000_0009, 32'h0000_000A, 32'h0000_0009);
        exp_q.push_back('{64'h0000_0009_0000_000A, 1'b0, 4});
        start(1'b0, '0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if ({lat, resp_rdata, resp_err} !== {e.lat, e.rdata, e.err}) begin
            errors++; $display("FAIL midrst_recover: got %0d/%h/%b expected %0d/%h/%b", lat, resp_rdata, resp_err, e.lat, e.rdata, e.err);
        end
        finish_resp();
    endtask

    initial begin
        test_reset();
        test_read_stable();
        test_read_retry();
        test_write();
        test_read_error();
        test_back_to_back();
        test_hold();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
